set_bit_iterator: RTL and testbench

//  Consumes a WIDTH-bit request/pending bitmap and emits the index of each set bit, one per

---
 rtl/set_bit_iterator_pkg.sv | 28 ++
 rtl/set_bit_iterator_pick.sv | 39 +++
 rtl/set_bit_iterator.sv | 137 +++++++++++++
 tb/tb_set_bit_iterator.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/set_bit_iterator_pkg.sv
// Shared types and helpers for the set-bit iterator.
package set_bit_iterator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } iter_state_t;

    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;

    // Widest bitmap the popcount helper accepts; callers zero-extend into it.
    localparam int POPCOUNT_MAX_W = 1024;

    // Number of set bits among the low i_width bits of i_vec.
    function automatic int unsigned popcount(input logic [POPCOUNT_MAX_W-1:0] i_vec,
                                             input int                       i_width);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < POPCOUNT_MAX_W; i++) begin
            if (i < i_width && i_vec[i]) begin
                cnt = cnt + 32'd1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/set_bit_iterator_pick.sv
// Combinational picker: selects the lowest (LSB-first) or highest (MSB-first)
// set bit of the pending bitmap and reports its index and one-hot mask.
module set_bit_iterator_pick
    import set_bit_iterator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_pending,
    input  logic             i_dir,
    output logic [IW-1:0]    o_idx,
    output logic [WIDTH-1:0] o_onehot,
    output logic             o_any
);

    // Later loop iterations overwrite earlier ones, so scan order decides which set bit wins.
    always_comb begin
        o_idx = '0;
        o_any = |i_pending;
        if (i_dir == DIR_MSB) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i_pending[i]) begin
                    o_idx = IW'(i);
                end
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (i_pending[i]) begin
                    o_idx = IW'(i);
                end
            end
        end
        o_onehot = '0;
        if (o_any) begin
            o_onehot = WIDTH'(1) << o_idx;
        end
    end

endmodule

// File: rtl/set_bit_iterator.sv
// Set-bit iterator top: accepts a bitmap and streams out the index of every
// set bit, one per handshake, LSB-first or MSB-first.
// Optional feature macro: SET_BIT_ITERATOR_STATS_EN adds a saturating
// o_pop_count output that counts every consumed index.
module set_bit_iterator
    import set_bit_iterator_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter     INSTANCE_NAME = "",
    localparam int IW           = $clog2(WIDTH),
    localparam int CW           = IW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_load_msb,
    output logic             o_idx_valid,
    input  logic             i_idx_ready,
    output logic [IW-1:0]    o_idx,
    output logic             o_idx_last,
    output logic [CW-1:0]    o_remaining,
    output logic             o_zero_load,
`ifdef SET_BIT_ITERATOR_STATS_EN
    output logic [31:0]      o_pop_count,
`endif
    input  logic             i_flush
);

    iter_state_t      r_state;
    iter_state_t      w_stateNext;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] w_pendingNext;
    logic             r_dir;
    logic             w_dirNext;
    logic [CW-1:0]    r_remaining;
    logic [CW-1:0]    w_remainingNext;
    logic             r_zeroLoad;
    logic             w_zeroLoadNext;
    logic             w_loadFire;
    logic             w_popFire;
    logic [IW-1:0]    w_idx;
    logic [WIDTH-1:0] w_onehot;
    logic             w_any;

    set_bit_iterator_pick #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_pick (
        .i_pending (r_pending),
        .i_dir     (r_dir),
        .o_idx     (w_idx),
        .o_onehot  (w_onehot),
        .o_any     (w_any)
    );

    // Index outputs depend only on registered state, never on this cycle's inputs.
    assign o_idx       = w_idx;
    assign o_idx_last  = (r_state == SCAN) && (r_remaining == CW'(1));
    assign o_remaining = r_remaining;
    assign o_zero_load = r_zeroLoad;

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and handshake decode; flush outranks load and pop.
    always_comb begin
        w_stateNext     = r_state;
        w_pendingNext   = r_pending;
        w_dirNext       = r_dir;
        w_remainingNext = r_remaining;
        w_zeroLoadNext  = 1'b0;
        o_load_ready    = (r_state == IDLE);
        o_idx_valid     = (r_state == SCAN) && w_any;
        w_loadFire      = o_load_ready && i_load_valid;
        w_popFire       = o_idx_valid && i_idx_ready;

        if (i_flush) begin
            w_stateNext     = IDLE;
            w_pendingNext   = '0;
            w_remainingNext = '0;
        end else if (w_loadFire) begin
            if (|i_load_data) begin
                w_stateNext     = SCAN;
                w_pendingNext   = i_load_data;
                w_dirNext       = i_load_msb;
                w_remainingNext = CW'(popcount(POPCOUNT_MAX_W'(i_load_data), WIDTH));
            end else begin
                w_zeroLoadNext = 1'b1;
            end
        end else if (w_popFire) begin
            w_pendingNext   = r_pending & ~w_onehot;
            w_remainingNext = r_remaining - CW'(1);
            if (o_idx_last) begin
                w_stateNext = IDLE;
            end
        end
    end

    // Pending bitmap, direction, remaining count and zero-load pulse registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pending   <= '0;
            r_dir       <= DIR_LSB;
            r_remaining <= '0;
            r_zeroLoad  <= 1'b0;
        end else begin
            r_pending   <= w_pendingNext;
            r_dir       <= w_dirNext;
            r_remaining <= w_remainingNext;
            r_zeroLoad  <= w_zeroLoadNext;
        end
    end

`ifdef SET_BIT_ITERATOR_STATS_EN
    logic [31:0] r_popCount;

    assign o_pop_count = r_popCount;

    // Saturating count of consumed indices; only reset clears it, flush does not.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_popCount <= '0;
        end else if (w_popFire && !i_flush && (r_popCount != 32'hFFFF_FFFF)) begin
            r_popCount <= r_popCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_set_bit_iterator.sv
// Scoreboard testbench for set_bit_iterator (WIDTH=8); also covers the
// SET_BIT_ITERATOR_STATS_EN build when that macro is defined.
module tb_set_bit_iterator;

    localparam int WIDTH = 8;
    localparam int IW    = 3;
    localparam int CW    = 4;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_load_valid;
    logic             o_load_ready;
    logic [WIDTH-1:0] i_load_data;
    logic             i_load_msb;
    logic             o_idx_valid;
    logic             i_idx_ready;
    logic [IW-1:0]    o_idx;
    logic             o_idx_last;
    logic [CW-1:0]    o_remaining;
    logic             o_zero_load;
    logic             i_flush;
`ifdef SET_BIT_ITERATOR_STATS_EN
    logic [31:0]      o_pop_count;
`endif

    always #5 i_clk = ~i_clk;

    set_bit_iterator #(
        .WIDTH         (WIDTH),
        .INSTANCE_NAME ("dut")
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load_valid (i_load_valid),
        .o_load_ready (o_load_ready),
        .i_load_data  (i_load_data),
        .i_load_msb   (i_load_msb),
        .o_idx_valid  (o_idx_valid),
        .i_idx_ready  (i_idx_ready),
        .o_idx        (o_idx),
        .o_idx_last   (o_idx_last),
        .o_remaining  (o_remaining),
        .o_zero_load  (o_zero_load),
`ifdef SET_BIT_ITERATOR_STATS_EN
        .o_pop_count  (o_pop_count),
`endif
        .i_flush      (i_flush)
    );

    typedef struct {
        logic [IW-1:0] idx;
        logic          last;
        logic [CW-1:0] rem;
    } exp_t;

    exp_t          expQ[$];
    int            total = 0;
    int            bad = 0;
    int            modelPops = 0;
    bit            monEnable = 1'b0;
    bit            holdValid = 1'b0;
    logic [IW-1:0] holdIdx;
    logic          holdLast;
    logic [CW-1:0] holdRem;

    // One comparison: counts it, and reports it when the values differ.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Reference model: list the set positions, order them, and emit one entry per position.
    task automatic pushExpected(input logic [WIDTH-1:0] data, input logic msb);
        int positions[$];
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) positions.push_back(i);
        end
        if (msb) positions.reverse();
        for (int n = 0; n < positions.size(); n++) begin
            exp_t e;
            e.idx  = IW'(positions[n]);
            e.rem  = CW'(positions.size() - n);
            e.last = (n == positions.size() - 1);
            expQ.push_back(e);
        end
    endtask

    // Offer one bitmap once the DUT is idle and queue its expected index stream.
    task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic msb);
        int waitCycles = 0;
        while (o_load_ready !== 1'b1 && waitCycles < 50) begin
            tick();
            waitCycles++;
        end
        checkOutput("load_ready_idle", o_load_ready, 1);
        i_load_valid = 1'b1;
        i_load_data  = data;
        i_load_msb   = msb;
        pushExpected(data, msb);
        tick();
        i_load_valid = 1'b0;
        i_load_data  = WIDTH'($urandom);
        i_load_msb   = 1'($urandom);
        if (data == '0) begin
            checkOutput("zero_load_pulse", o_zero_load, 1);
            checkOutput("zero_no_valid", o_idx_valid, 0);
            tick();
            checkOutput("zero_load_clear", o_zero_load, 0);
            checkOutput("zero_still_idle", o_load_ready, 1);
        end else begin
            checkOutput("latency_valid", o_idx_valid, 1);
        end
    endtask

    // Consume the queued indices with ready held (0), toggling (1) or random (2).
    task automatic drain(input int mode, input int k);
        int cycles = 0;
        bit tog = 1'b1;
        while (expQ.size() > 0 && cycles < 200) begin
            case (mode)
                0:       i_idx_ready = 1'b1;
                1:       begin i_idx_ready = tog; tog = ~tog; end
                default: i_idx_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            cycles++;
        end
        i_idx_ready = 1'b0;
        checkOutput("drain_complete", expQ.size(), 0);
        if (mode == 0) checkOutput("throughput_cycles", cycles, k);
        checkOutput("load_ready_after_last", o_load_ready, 1);
        checkOutput("valid_low_after_last", o_idx_valid, 0);
    endtask

    // Monitor: checks held outputs during stalls and scores every accepted index.
    always @(negedge i_clk) begin
        if (!i_rst_n) modelPops = 0;
        if (monEnable && i_rst_n && !i_flush) begin
            if (holdValid) begin
                checkOutput("stall_idx_hold", o_idx, holdIdx);
                checkOutput("stall_last_hold", o_idx_last, holdLast);
                checkOutput("stall_rem_hold", o_remaining, holdRem);
            end
            if (o_idx_valid && i_idx_ready) begin
                holdValid = 1'b0;
                checkOutput("queue_nonempty", expQ.size() > 0, 1);
                if (expQ.size() > 0) begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("idx", o_idx, e.idx);
                    checkOutput("idx_last", o_idx_last, e.last);
                    checkOutput("remaining", o_remaining, e.rem);
                    modelPops++;
                end
            end else if (o_idx_valid) begin
                holdValid = 1'b1;
                holdIdx   = o_idx;
                holdLast  = o_idx_last;
                holdRem   = o_remaining;
            end else begin
                holdValid = 1'b0;
            end
        end else begin
            holdValid = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired before completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [WIDTH-1:0] rdata;
        logic             rmsb;

        i_rst_n      = 1'b0;
        i_load_valid = 1'b0;
        i_load_data  = '0;
        i_load_msb   = 1'b0;
        i_idx_ready  = 1'b0;
        i_flush      = 1'b0;
        repeat (3) tick();
        checkOutput("rst_load_ready", o_load_ready, 1);
        checkOutput("rst_idx_valid", o_idx_valid, 0);
        checkOutput("rst_idx", o_idx, 0);
        checkOutput("rst_idx_last", o_idx_last, 0);
        checkOutput("rst_remaining", o_remaining, 0);
        checkOutput("rst_zero_load", o_zero_load, 0);
`ifdef SET_BIT_ITERATOR_STATS_EN
        checkOutput("rst_pop_count", o_pop_count, 0);
`endif
        i_rst_n   = 1'b1;
        monEnable = 1'b1;
        tick();

        $display("[TB] LSB-first and MSB-first walks of 8'b1010_0100");
        applyStimulus(8'b1010_0100, 1'b0);
        drain(0, 3);
        applyStimulus(8'b1010_0100, 1'b1);
        drain(0, 3);

        $display("[TB] all-zero load");
        applyStimulus(8'h00, 1'b0);

        $display("[TB] full bitmap with toggling ready");
        applyStimulus(8'hFF, 1'b0);
        drain(1, 8);

        $display("[TB] flush after two pops, load ignored during scan");
        applyStimulus(8'hFF, 1'b0);
        i_idx_ready = 1'b1;
        tick();
        tick();
        i_idx_ready  = 1'b0;
        i_load_valid = 1'b1;
        i_load_data  = 8'h0F;
        tick();
        i_load_valid = 1'b0;
        checkOutput("scan_load_ready_low", o_load_ready, 0);
        checkOutput("scan_load_ignored_rem", o_remaining, 6);
        checkOutput("scan_load_ignored_idx", o_idx, 2);
        i_flush     = 1'b1;
        i_idx_ready = 1'b1;
        tick();
        i_flush     = 1'b0;
        i_idx_ready = 1'b0;
        expQ.delete();
        checkOutput("flush_valid", o_idx_valid, 0);
        checkOutput("flush_remaining", o_remaining, 0);
        checkOutput("flush_load_ready", o_load_ready, 1);

        $display("[TB] flush in idle suppresses load");
        i_flush      = 1'b1;
        i_load_valid = 1'b1;
        i_load_data  = 8'h33;
        tick();
        i_flush      = 1'b0;
        i_load_valid = 1'b0;
        checkOutput("idle_flush_valid", o_idx_valid, 0);
        checkOutput("idle_flush_ready", o_load_ready, 1);
        checkOutput("idle_flush_rem", o_remaining, 0);

        $display("[TB] reset in the middle of a scan of 8'h81");
        applyStimulus(8'h81, 1'b0);
        i_idx_ready = 1'b1;
        tick();
        i_idx_ready = 1'b0;
        checkOutput("pre_reset_idx", o_idx, 7);
        i_rst_n     = 1'b0;
        i_idx_ready = 1'b1;
        tick();
        i_rst_n     = 1'b1;
        i_idx_ready = 1'b0;
        expQ.delete();
        checkOutput("midrst_valid", o_idx_valid, 0);
        checkOutput("midrst_idx", o_idx, 0);
        checkOutput("midrst_last", o_idx_last, 0);
        checkOutput("midrst_remaining", o_remaining, 0);
        checkOutput("midrst_load_ready", o_load_ready, 1);
`ifdef SET_BIT_ITERATOR_STATS_EN
        checkOutput("midrst_pop_count", o_pop_count, 0);
`endif

        $display("[TB] randomized bitmaps");
        for (int n = 0; n < 30; n++) begin
            rdata = WIDTH'($urandom);
            if ($urandom_range(0, 5) == 0) rdata = '0;
            rmsb = 1'($urandom);
            applyStimulus(rdata, rmsb);
            if (rdata != '0) drain($urandom_range(0, 2), $countones(rdata));
        end

`ifdef SET_BIT_ITERATOR_STATS_EN
        tick();
        checkOutput("pop_count_total", o_pop_count, modelPops);
`endif

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
